// File: rtl/div_iter_pkg.sv
// Shared definitions for the iterative divider: state encodings, default width,
// and the DIV/DIVU funct codes decoded upstream.
package div_iter_pkg;

    localparam int DIV_WIDTH = 32;

    localparam logic [5:0] funct_div  = 6'h1a;
    localparam logic [5:0] funct_divu = 6'h1b;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring division iteration: shift {rem,quo} left, trial-subtract the
// divisor, keep the difference and set the quotient bit when there is no borrow.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] dvs,
    output logic [WIDTH-1:0] rem_nxt,
    output logic [WIDTH-1:0] quo_nxt
);

    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] diff;

    // trial subtract one bit wider than the operands so the top bit is the borrow
    always_comb begin
        rem_sh = {rem, quo[WIDTH-1]};
        diff   = rem_sh - {1'b0, dvs};
        if (!diff[WIDTH]) begin
            rem_nxt = diff[WIDTH-1:0];
            quo_nxt = {quo[WIDTH-2:0], 1'b1};
        end else begin
            rem_nxt = rem_sh[WIDTH-1:0];
            quo_nxt = {quo[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div_iter.sv
// Iterative DIV/DIVU unit for the execute stage. Magnitudes are divided with one
// restoring step per cycle, then signs are fixed up (remainder follows dividend).
// Optional: DIV_ZERO_FAST_EN completes a divide by zero in one cycle.
module div_iter
    import div_iter_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             isdiv,
    input  logic             signeddiv,
    input  logic             annul,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             stall,
    output logic             ready,
    output logic [WIDTH-1:0] lo_out,
    output logic [WIDTH-1:0] hi_out
);

    localparam int CW = $clog2(WIDTH);

    div_state_e       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem, quo, dvs;
    logic [WIDTH-1:0] rem_nxt, quo_nxt;
    logic             qneg, rneg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic             a_neg, b_neg;
    logic             accept;

    // operand magnitudes and sign flags for the incoming request
    always_comb begin
        a_neg  = signeddiv & a[WIDTH-1];
        b_neg  = signeddiv & b[WIDTH-1];
        a_mag  = a_neg ? -a : a;
        b_mag  = b_neg ? -b : b;
        accept = (state == DIV_IDLE) & isdiv & ~annul;
        stall  = accept | (state == DIV_BUSY);
    end

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem     (rem),
        .quo     (quo),
        .dvs     (dvs),
        .rem_nxt (rem_nxt),
        .quo_nxt (quo_nxt)
    );

    // control FSM, iteration counter, operand registers and registered results
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= DIV_IDLE;
            cnt    <= '0;
            rem    <= '0;
            quo    <= '0;
            dvs    <= '0;
            qneg   <= 1'b0;
            rneg   <= 1'b0;
            ready  <= 1'b0;
            lo_out <= '0;
            hi_out <= '0;
        end else begin
            case (state)
                DIV_IDLE: begin
                    ready <= 1'b0;
                    if (accept) begin
                        qneg <= a_neg ^ b_neg;
                        rneg <= a_neg;
                        rem  <= '0;
                        quo  <= a_mag;
                        dvs  <= b_mag;
                        cnt  <= '0;
`ifdef DIV_ZERO_FAST_EN
                        if (b == '0) begin
                            // same values the iterative path yields: q=all ones, r=|a|
                            lo_out <= a_neg ? {{(WIDTH-1){1'b0}}, 1'b1} : '1;
                            hi_out <= a;
                            ready  <= 1'b1;
                            state  <= DIV_DONE;
                        end else begin
                            state  <= DIV_BUSY;
                        end
`else
                        state <= DIV_BUSY;
`endif
                    end
                end
                DIV_BUSY: begin
                    if (annul) begin
                        state <= DIV_IDLE;
                    end else begin
                        rem <= rem_nxt;
                        quo <= quo_nxt;
                        cnt <= cnt + 1'b1;
                        if (cnt == CW'(WIDTH-1)) begin
                            lo_out <= qneg ? -quo_nxt : quo_nxt;
                            hi_out <= rneg ? -rem_nxt : rem_nxt;
                            ready  <= 1'b1;
                            state  <= DIV_DONE;
                        end
                    end
                end
                default: begin
                    // DONE lasts one cycle; isdiv here belongs to the finishing instruction
                    ready <= 1'b0;
                    state <= DIV_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_iter.sv
// Randomized self-checking bench for div_iter against an arithmetic reference.
module tb_div_iter;

    logic        clk = 1'b0;
    logic        rst;
    logic        isdiv, signeddiv, annul;
    logic [31:0] a, b;
    logic        stall, ready;
    logic [31:0] lo_out, hi_out;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    div_iter dut (
        .clk       (clk),
        .rst       (rst),
        .isdiv     (isdiv),
        .signeddiv (signeddiv),
        .annul     (annul),
        .a         (a),
        .b         (b),
        .stall     (stall),
        .ready     (ready),
        .lo_out    (lo_out),
        .hi_out    (hi_out)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // reference: divide magnitudes, then apply C-style signs (remainder follows dividend)
    function automatic void model(input bit s, input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] q, output logic [31:0] r);
        logic [31:0] mx, my, mq, mr;
        bit xn, yn;
        xn = s && x[31];
        yn = s && y[31];
        mx = xn ? 32'(0 - x) : x;
        my = yn ? 32'(0 - y) : y;
        if (my == 0) begin
            mq = 32'hFFFF_FFFF;
            mr = mx;
        end else begin
            mq = mx / my;
            mr = mx % my;
        end
        q = (xn != yn) ? 32'(0 - mq) : mq;
        r = xn ? 32'(0 - mr) : mr;
    endfunction

    function automatic int exp_lat(input logic [31:0] y);
`ifdef DIV_ZERO_FAST_EN
        if (y == 0) return 1;
`endif
        return 33;
    endfunction

    // issue at negedge, sampled at the following posedge (edge T)
    task automatic issue(input bit s, input logic [31:0] x, input logic [31:0] y, input string tag);
        @(negedge clk);
        isdiv = 1'b1; signeddiv = s; a = x; b = y;
        #1;
        check({tag, ".stall_T"}, 64'(stall), 64'd1);
        @(posedge clk);
        #1;
        isdiv = 1'b0; a = $urandom; b = $urandom; signeddiv = $urandom_range(0, 1);
    endtask

    task automatic do_div(input bit s, input logic [31:0] x, input logic [31:0] y, input string tag);
        logic [31:0] q, r;
        int lat, low_stall;
        model(s, x, y, q, r);
        issue(s, x, y, tag);
        lat = 0; low_stall = 0;
        do begin
            @(negedge clk);
            lat++;
            if (!ready && !stall) low_stall++;
        end while (!ready && lat < 100);
        check({tag, ".lat"}, 64'(lat), 64'(exp_lat(y)));
        check({tag, ".stall_gap"}, 64'(low_stall), 64'd0);
        check({tag, ".stall_done"}, 64'(stall), 64'd0);
        check({tag, ".res"}, {hi_out, lo_out}, {r, q});
        @(negedge clk);
        check({tag, ".hold"}, {31'd0, ready, hi_out, lo_out}, {32'd0, r, q});
    endtask

    initial begin
        logic [31:0] q0, r0, x, y;
        int k;
        rst = 1'b1; isdiv = 1'b0; signeddiv = 1'b0; annul = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_state", {30'd0, stall, ready, hi_out, lo_out}, 96'd0);
        rst = 1'b0;

        do_div(1'b0, 32'd100, 32'd7, "divu_100_7");
        do_div(1'b1, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
        check("div_m7_2.lit", {hi_out, lo_out}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        do_div(1'b1, 32'd7, 32'hFFFF_FFFE, "div_7_m2");
        check("div_7_m2.lit", {hi_out, lo_out}, {32'd1, 32'hFFFF_FFFD});
        do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        check("div_ovf.lit", {hi_out, lo_out}, {32'd0, 32'h8000_0000});
        do_div(1'b0, 32'd5, 32'd0, "divu_5_0");
        check("divu_5_0.lit", {hi_out, lo_out}, {32'd5, 32'hFFFF_FFFF});
        do_div(1'b1, 32'hFFFF_FFFB, 32'd0, "div_m5_0");
        check("div_m5_0.lit", {hi_out, lo_out}, {32'hFFFF_FFFB, 32'd1});

        // annul mid-operation: back to IDLE, no ready, outputs untouched
        model(1'b1, 32'hFFFF_FFFB, 32'd0, q0, r0);
        issue(1'b0, 32'd1000, 32'd3, "annul");
        k = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (ready) k++;
        end
        annul = 1'b1;
        @(negedge clk);
        annul = 1'b0;
        check("annul.ready", 64'(k + int'(ready)), 64'd0);
        check("annul.stall", 64'(stall), 64'd0);
        check("annul.out", {hi_out, lo_out}, {r0, q0});
        k = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ready) k++;
        end
        check("annul.noready", 64'(k), 64'd0);
        do_div(1'b0, 32'd9, 32'd3, "divu_9_3");

        // reset in BUSY
        issue(1'b1, 32'h1234_5678, 32'd77, "rst_busy");
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_busy.state", {30'd0, stall, ready, hi_out, lo_out}, 96'd0);
        k = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ready) k++;
        end
        check("rst_busy.noready", 64'(k), 64'd0);

        // randomized operands with boundary-biased divisors
        for (int i = 0; i < 40; i++) begin
            x = $urandom;
            case ($urandom_range(0, 5))
                0: y = 32'd0;
                1: y = 32'd1;
                2: y = 32'hFFFF_FFFF;
                3: y = 32'($urandom_range(2, 300));
                4: y = 32'h8000_0000;
                default: y = $urandom;
            endcase
            if ($urandom_range(0, 7) == 0) x = 32'h8000_0000;
            do_div(1'($urandom_range(0, 1)), x, y, $sformatf("rnd%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
